// File: rtl/psoa_pkg.sv
// Shared fixed-point types, constants and helpers for the shared sigmoid arbiter.
package psoa_pkg;

  localparam int          FRAC_BITS     = 10;
  localparam logic [15:0] Q_ONE         = 16'd1024;
  localparam int          SAT_LIMIT_DEF = 8192;
  localparam int          TAG_ID_W      = 3;

  typedef logic signed [15:0] fix_t;
  typedef logic [15:0]        ufix_t;

  typedef struct packed {
    logic [TAG_ID_W-1:0] id;
    logic                sign;
  } sig_tag_t;

  // Magnitude is formed in 17 bits so that -32768 becomes +32768 before clipping.
  function automatic ufix_t sat_mag(fix_t x, logic [16:0] limit);
    logic [16:0] mag;
    mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
    return (mag > limit) ? limit[15:0] : mag[15:0];
  endfunction

endpackage

// File: rtl/psoa_sigmoid.sv
// Unsigned sigmoid core: piecewise-linear f(x) for x >= 0 in Q5.10, result in Q.10.
// Output appears LAT clocks after x is sampled.
module psoa_sigmoid
  import psoa_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  output logic [15:0] f_x
);

  localparam logic [15:0] ONE_IN  = 16'(1 << FRAC_BITS);
  localparam logic [15:0] KNEE_IN = 16'(19 << (FRAC_BITS - 3));
  localparam logic [15:0] FLAT_IN = 16'(5 << FRAC_BITS);

  ufix_t w_f;
  ufix_t r_pipe [LAT];

  // Slopes 1/4, 1/8, 1/32 with breakpoints at 1.0, 2.375 and 5.0.
  always_comb begin
    w_f = Q_ONE;
    if (x < ONE_IN) begin
      w_f = 16'd512 + (x >> 2);
    end else if (x < KNEE_IN) begin
      w_f = 16'd640 + (x >> 3);
    end else if (x < FLAT_IN) begin
      w_f = 16'd864 + (x >> 5);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_f;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign f_x = r_pipe[LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter; the pointer moves to the granted id only on acknowledge.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic          i_ack,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_id
);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  int            w_idx;

  // Search starts just after the last winner and wraps, so the last winner is lowest priority.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[IW'(w_idx)]) begin
        w_found    = 1'b1;
        o_grant_id = IW'(w_idx);
      end
    end
    if (w_found && i_en) begin
      o_grant[o_grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IW'(N - 1);
    end else if (i_ack) begin
      r_ptr <= o_grant_id;
    end
  end

endmodule

// File: rtl/psoa_sigmoid_arbiter.sv
// Shares one psoa_sigmoid core among N_REQ requesters, using sign symmetry around the
// unsigned core and a credit-guarded result FIFO that returns results in issue order.
module psoa_sigmoid_arbiter
  import psoa_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int CORE_LAT   = 1,
  parameter  int FIFO_DEPTH = 4,
  parameter  int SAT_LIMIT  = SAT_LIMIT_DEF,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*16-1:0]   req_x,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_f,
  input  logic                  rsp_ready
);

  localparam int          CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int          PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [16:0] SAT_17 = 17'(SAT_LIMIT);

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_issue;
  logic             w_pop;
  logic             w_push;
  fix_t             w_sel_x;
  ufix_t            w_sat;
  ufix_t            w_f_core;
  ufix_t            w_fc;
  ufix_t            w_res;

  logic [CRED_W-1:0] r_credits;
  ufix_t             r_x;
  logic              r_tag_v [CORE_LAT+1];
  sig_tag_t          r_tag   [CORE_LAT+1];

  logic [ID_W-1:0]   r_mem_id [FIFO_DEPTH];
  ufix_t             r_mem_f  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [CRED_W-1:0] r_count;

  // Ready is forced low during reset so no requester sees a grant before credits are valid.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk        (clk),
    .rst        (reset),
    .i_req      (req_valid),
    .i_en       ((r_credits != '0) && !reset),
    .i_ack      (w_issue),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  assign req_ready = w_grant;
  assign w_issue   = |w_grant;

  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_x = req_x[16*i +: 16];
      end
    end
  end

  assign w_sat = sat_mag(w_sel_x, SAT_17);

  // Stage 0 lines up with r_x; stage CORE_LAT lines up with the core output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      for (int i = 0; i <= CORE_LAT; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else begin
      if (w_issue) begin
        r_x <= w_sat;
      end
      r_tag_v[0] <= w_issue;
      r_tag[0]   <= '{id: TAG_ID_W'(w_grant_id), sign: w_sel_x[15]};
      for (int i = 1; i <= CORE_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  psoa_sigmoid #(.LAT(CORE_LAT)) u_core (
    .clk (clk),
    .rst (reset),
    .x   (r_x),
    .f_x (w_f_core)
  );

  assign w_fc   = (w_f_core > Q_ONE) ? Q_ONE : w_f_core;
  assign w_res  = r_tag[CORE_LAT].sign ? (Q_ONE - w_fc) : w_fc;
  assign w_push = r_tag_v[CORE_LAT];
  assign w_pop  = (r_count != '0) && rsp_ready;

  // One credit per FIFO slot covers both in-flight and queued results, so a push never overflows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits <= CRED_W'(FIFO_DEPTH);
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_id[i] <= '0;
        r_mem_f[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_id[r_wr] <= r_tag[CORE_LAT].id[ID_W-1:0];
        r_mem_f[r_wr]  <= w_res;
        r_wr           <= (r_wr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= (r_rd == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid = (r_count != '0);
  assign rsp_id    = rsp_valid ? r_mem_id[r_rd] : '0;
  assign rsp_f     = rsp_valid ? r_mem_f[r_rd]  : '0;

endmodule

// File: tb/tb_psoa_sigmoid_arbiter.sv
// Directed and randomized bench for psoa_sigmoid_arbiter against a queue-based reference.
module tb_psoa_sigmoid_arbiter;

  localparam int N_REQ      = 4;
  localparam int CORE_LAT   = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int SAT        = 8192;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*16-1:0] req_x;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [15:0]         rsp_f;
  logic                rsp_ready;

  always #5 clk = ~clk;

  psoa_sigmoid_arbiter #(
    .N_REQ(N_REQ), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .SAT_LIMIT(SAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f),
    .rsp_ready (rsp_ready)
  );

  typedef struct {
    int id;
    int f;
    int avail;
  } exp_t;

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;
  int hsCount    = 0;
  int popCount   = 0;
  int lastGrant  = N_REQ - 1;
  int lastHsCycle, lastPopCycle, lastPopId, lastPopF;

  logic [N_REQ-1:0]  holdValid;
  logic signed [15:0] holdX [N_REQ];
  logic              rspReadyHold;
  exp_t              sb[$];
  int                grantLog[$];

  // Core reference: piecewise-linear sigmoid segments (start, offset, divisor) on |x| in Q5.10.
  function automatic int refCore(input int m);
    int segStart [3] = '{0, 1024, 2432};
    int segOff   [3] = '{512, 640, 864};
    int segDiv   [3] = '{4, 8, 32};
    if (m >= 5120) return 1024;
    for (int s = 2; s >= 0; s--) begin
      if (m >= segStart[s]) return segOff[s] + m / segDiv[s];
    end
    return 0;
  endfunction

  function automatic int refSigmoid(input int x);
    int m = (x < 0) ? -x : x;
    int f;
    if (m > SAT) m = SAT;
    f = refCore(m);
    if (f > 1024) f = 1024;
    return (x < 0) ? 1024 - f : f;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic applyStimulus();
    req_valid = holdValid;
    for (int i = 0; i < N_REQ; i++) req_x[16*i +: 16] = holdX[i];
    rsp_ready = rspReadyHold;
  endtask

  // Expected grant follows the rule "first valid after the last winner, if a FIFO slot is free".
  task automatic checkOutput();
    logic [N_REQ-1:0] expReady;
    logic             expValid;
    expReady = '0;
    if (sb.size() < FIFO_DEPTH) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int idx = (lastGrant + k) % N_REQ;
        if (holdValid[idx]) begin
          expReady[idx] = 1'b1;
          break;
        end
      end
    end
    checkVal("req_ready", 32'(req_ready), 32'(expReady));
    expValid = (sb.size() > 0) && (sb[0].avail <= cycle);
    checkVal("rsp_valid", 32'(rsp_valid), 32'(expValid));
    if (expValid && rsp_valid) begin
      checkVal("rsp_id", 32'(rsp_id), sb[0].id);
      checkVal("rsp_f", 32'(rsp_f), sb[0].f);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sb.push_back('{id: i, f: refSigmoid(int'(holdX[i])), avail: cycle + CORE_LAT + 2});
        lastGrant    = i;
        holdValid[i] = 1'b0;
        hsCount++;
        lastHsCycle  = cycle;
        grantLog.push_back(i);
      end
    end
    if (rsp_valid && rsp_ready && sb.size() > 0) begin
      lastPopId    = int'(rsp_id);
      lastPopF     = int'(rsp_f);
      lastPopCycle = cycle;
      void'(sb.pop_front());
      popCount++;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    cycle++;
    #1;
    applyStimulus();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic refill(input logic [N_REQ-1:0] mask, input bit zeroX);
    for (int i = 0; i < N_REQ; i++) begin
      if (mask[i] && !holdValid[i]) begin
        holdX[i]     = zeroX ? 16'sd0 : 16'($urandom_range(0, 65535));
        holdValid[i] = 1'b1;
      end
    end
  endtask

  task automatic runHandshakes(input string tag, input logic [N_REQ-1:0] mask, input bit zeroX,
                               input int count, input int budget);
    int target = hsCount + count;
    int n = 0;
    while (hsCount < target && n < budget) begin
      refill(mask, zeroX);
      stepCycle();
      n++;
    end
    checkVal(tag, hsCount - (target - count), count);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || holdValid != '0) && n < budget) begin
      stepCycle();
      n++;
    end
    checkVal(tag, sb.size() + $countones(holdValid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int f1, f2, hsBefore, popBefore, failBefore, sweepIdx, sweepPops, n;
    int gexp [6] = '{0, 1, 2, 0, 1, 2};

    holdValid    = '0;
    rspReadyHold = 1'b0;
    for (int i = 0; i < N_REQ; i++) holdX[i] = 16'sd0;
    reset = 1'b1;
    applyStimulus();
    req_valid = '1;
    repeat (2) @(negedge clk);
    checkVal("reset_req_ready", 32'(req_ready), 0);
    checkVal("reset_rsp_valid", 32'(rsp_valid), 0);
    checkVal("reset_rsp_id", 32'(rsp_id), 0);
    checkVal("reset_rsp_f", 32'(rsp_f), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus();

    $display("[TB] case 1: +2.5 on req0");
    rspReadyHold = 1'b1;
    holdX[0] = 16'sd2560;
    holdValid = 4'b0001;
    waitIdle("c1_drain", 20);
    checkVal("c1_id", lastPopId, 0);
    checkVal("c1_f", lastPopF, refSigmoid(2560));
    checkVal("c1_latency", lastPopCycle - lastHsCycle, CORE_LAT + 2);
    f1 = lastPopF;

    $display("[TB] case 2: -2.5 on req1");
    holdX[1] = -16'sd2560;
    holdValid = 4'b0010;
    waitIdle("c2_drain", 20);
    checkVal("c2_id", lastPopId, 1);
    f2 = lastPopF;
    checkVal("c2_symmetry_sum", f1 + f2, 1024);
    checkVal("c2_latency", lastPopCycle - lastHsCycle, CORE_LAT + 2);

    holdX[3] = 16'($urandom_range(0, 65535));
    holdValid = 4'b1000;
    waitIdle("c2b_drain", 20);

    $display("[TB] case 3: req0..2 continuously valid, x=0");
    grantLog.delete();
    runHandshakes("c3_handshakes", 4'b0111, 1'b1, 6, 30);
    holdValid = '0;
    for (int i = 0; i < 6; i++)
      checkVal($sformatf("c3_grant%0d", i), (grantLog.size() > i) ? grantLog[i] : -1, gexp[i]);
    waitIdle("c3_drain", 20);

    $display("[TB] case 4: backpressure with FIFO_DEPTH credits");
    rspReadyHold = 1'b0;
    hsBefore  = hsCount;
    popBefore = popCount;
    repeat (10) begin
      refill('1, 1'b0);
      stepCycle();
    end
    checkVal("c4_handshakes", hsCount - hsBefore, FIFO_DEPTH);
    checkVal("c4_ready_blocked", 32'(req_ready), 0);
    refill('1, 1'b0);
    rspReadyHold = 1'b1;
    stepCycle();
    rspReadyHold = 1'b0;
    repeat (3) begin
      refill('1, 1'b0);
      stepCycle();
    end
    checkVal("c4_one_pop", popCount - popBefore, 1);
    checkVal("c4_one_more_grant", hsCount - hsBefore, FIFO_DEPTH + 1);
    holdValid = '0;
    rspReadyHold = 1'b1;
    waitIdle("c4_drain", 30);

    $display("[TB] case 5: saturation");
    popBefore = popCount;
    holdX[1] = 16'sh8000;
    holdX[2] = 16'sd12000;
    holdValid = 4'b0110;
    waitIdle("c5_drain", 20);
    checkVal("c5_pops", popCount - popBefore, 2);

    $display("[TB] case 6: reset with results queued and in flight");
    rspReadyHold = 1'b0;
    runHandshakes("c6_queue", 4'b0011, 1'b0, 2, 20);
    holdValid = '0;
    repeat (3) stepCycle();
    runHandshakes("c6_inflight", 4'b1100, 1'b0, 2, 20);
    holdValid = 4'b1111;
    @(posedge clk);
    #2;
    applyStimulus();
    reset = 1'b1;
    #1;
    checkVal("c6_reset_req_ready", 32'(req_ready), 0);
    checkVal("c6_reset_rsp_valid", 32'(rsp_valid), 0);
    checkVal("c6_reset_rsp_id", 32'(rsp_id), 0);
    checkVal("c6_reset_rsp_f", 32'(rsp_f), 0);
    sb.delete();
    holdValid = '0;
    lastGrant = N_REQ - 1;
    rspReadyHold = 1'b1;
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) stepCycle();
    grantLog.delete();
    runHandshakes("c6_regrant", '1, 1'b0, 1, 10);
    checkVal("c6_first_grant", (grantLog.size() > 0) ? grantLog[0] : -1, 0);
    holdValid = '0;
    waitIdle("c6_drain", 20);

    $display("[TB] sweep: x=-8192..8192 step 16, random requesters and backpressure");
    failBefore = checkCount - passCount;
    popBefore  = popCount;
    sweepIdx   = 0;
    n          = 0;
    while ((sweepIdx < 1025 || sb.size() != 0 || holdValid != '0) && n < 20000) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!holdValid[i] && sweepIdx < 1025 && $urandom_range(0, 1) == 1) begin
          holdX[i]     = 16'(-8192 + 16 * sweepIdx);
          holdValid[i] = 1'b1;
          sweepIdx++;
        end
      end
      rspReadyHold = ($urandom_range(0, 3) != 0);
      stepCycle();
      n++;
    end
    sweepPops = popCount - popBefore;
    checkVal("sweep_results", sweepPops, 1025);
    checkVal("sweep_mismatches", (checkCount - passCount) - failBefore, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
